// File: rtl/fft_s2p_pkg.sv
// Shared FFT front-end constants: converter width,
// FSM state encoding and default frame geometry.
package fft_s2p_pkg;

  localparam int PAR       = 4;
  localparam int PH_W      = 2;
  localparam int FFT_N_DEF = 1024;
  localparam int CNT_W_DEF = 10;
  localparam int GRP_W_DEF = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fft_phase_counter.sv
// Mod-4 converter phase plus frame sample counter,
// with a terminal-count flag on the last sample.
module fft_phase_counter
  import fft_s2p_pkg::*;
#(
  parameter int FFT_N = FFT_N_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             adv,
  output logic [PH_W-1:0]  phase,
  output logic [CNT_W-1:0] cnt,
  output logic             tc
);

  logic [PH_W-1:0]  phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tc = (cnt_q == CNT_W'(FFT_N - 1));

  // Advance on accepted beats; wrap both at frame end.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (clr) begin
      phase_d = '0;
      cnt_d   = '0;
    end else if (adv) begin
      if (tc) begin
        phase_d = '0;
        cnt_d   = '0;
      end else begin
        phase_d = phase_q + 1'b1;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase = phase_q;
  assign cnt   = cnt_q;

endmodule

// File: rtl/fft_s2p_sequencer.sv
// Sequencer for the 1-to-4 serial-to-parallel FFT front end.
// Optional stall counter: define S2P_DROP_CNT_EN.
module fft_s2p_sequencer
  import fft_s2p_pkg::*;
#(
  parameter int FFT_N = FFT_N_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int GRP_W = GRP_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             core_ready,
  output logic             s2p_enable,
  output logic [1:0]       s2p_counter,
  output logic             grp_valid,
  output logic [GRP_W-1:0] grp_addr,
  output logic             frame_busy,
  output logic             frame_done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [15:0]      drop_cnt
);

  logic [1:0]       state_q, state_d;
  logic             gv_q, gv_d;
  logic [GRP_W-1:0] ga_q, ga_d;
  logic             fd_q, fd_d;
  logic [PH_W-1:0]  phase;
  logic [CNT_W-1:0] cnt;
  logic             tc;
  logic             run;
  logic             beat;
  logic             clr;

  assign run  = (state_q == ST_RUN);
  // A group only completes when the core can take it.
  assign in_ready = run &
    ~((phase == 2'd3) & ~core_ready);
  assign beat = in_valid & in_ready;
  assign clr  = (state_q == ST_IDLE) & start;

  fft_phase_counter #(
    .FFT_N (FFT_N),
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .adv   (beat),
    .phase (phase),
    .cnt   (cnt),
    .tc    (tc)
  );

  // Frame FSM: arm on start, finish on the last beat.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (beat && tc) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Group strobe lines up with the converter's latched words.
  always_comb begin
    gv_d = beat & (phase == 2'd3);
    ga_d = ga_q;
    if (gv_d) ga_d = GRP_W'(cnt >> 2);
    fd_d = beat & tc;
  end

  // FSM and group output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      gv_q    <= 1'b0;
      ga_q    <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gv_q    <= gv_d;
      ga_q    <= ga_d;
      fd_q    <= fd_d;
    end
  end

`ifdef S2P_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  // Saturating count of stalled valid cycles.
  always_comb begin
    drop_d = drop_q;
    if (clr) begin
      drop_d = '0;
    end else if (run && in_valid &&
                 !in_ready &&
                 drop_q != 16'hFFFF) begin
      drop_d = drop_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_q <= '0;
    else      drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'd0;
`endif

  assign s2p_enable  = beat;
  assign s2p_counter = phase;
  assign grp_valid   = gv_q;
  assign grp_addr    = ga_q;
  assign frame_busy  = (state_q != ST_IDLE);
  assign frame_done  = fd_q;
  assign sample_cnt  = cnt;

endmodule

// File: tb/tb_fft_s2p_sequencer.sv
// Directed self-checking bench for fft_s2p_sequencer.
// Inputs change on negedge; outputs sampled 1 before posedge.
module tb_fft_s2p_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        core_ready;
  logic        s2p_enable;
  logic [1:0]  s2p_counter;
  logic        grp_valid;
  logic [7:0]  grp_addr;
  logic        frame_busy;
  logic        frame_done;
  logic [9:0]  sample_cnt;
  logic [15:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fft_s2p_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .core_ready  (core_ready),
    .s2p_enable  (s2p_enable),
    .s2p_counter (s2p_counter),
    .grp_valid   (grp_valid),
    .grp_addr    (grp_addr),
    .frame_busy  (frame_busy),
    .frame_done  (frame_done),
    .sample_cnt  (sample_cnt),
    .drop_cnt    (drop_cnt)
  );

  task automatic apply_reset();
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    core_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Streams a whole frame with core_ready=1; returns stats.
  task automatic run_frame(
    input  bit toggle,
    output int groups,
    output int addr_err,
    output int pos_err,
    output int en_err,
    output int done_cyc,
    output int last_addr
  );
    int exp_c;
    groups = 0; addr_err = 0; pos_err = 0;
    en_err = 0; done_cyc = -1; last_addr = -1;
    for (int c = 0; c < 2200; c++) begin
      @(negedge clk);
      in_valid = toggle ? (c % 2 == 0) : 1'b1;
      core_ready = 1'b1;
      #4;
      if (s2p_enable !== (in_valid & in_ready))
        en_err++;
      if (grp_valid === 1'b1) begin
        if (grp_addr !== groups[7:0]) addr_err++;
        exp_c = toggle ? 8 * groups + 7
                       : 4 * groups + 4;
        if (c != exp_c) pos_err++;
        last_addr = int'(grp_addr);
        groups++;
      end
      if (frame_done === 1'b1) begin
        done_cyc = c;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b1;
    core_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({in_ready, s2p_enable, s2p_counter,
         grp_valid, grp_addr, frame_busy,
         frame_done, sample_cnt, drop_cnt} !== '0) begin
      fails++;
      $display("FAIL reset_outs: got in_ready=%b cnt=%0d busy=%b scnt=%0d want all 0",
               in_ready, s2p_counter, frame_busy, sample_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    #4;
    tests++;
    if (in_ready !== 1'b0 || s2p_enable !== 1'b0 ||
        sample_cnt !== 10'd0) begin
      fails++;
      $display("FAIL idle_no_accept: got rdy=%b en=%b scnt=%0d want 0 0 0",
               in_ready, s2p_enable, sample_cnt);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_full_frame();
    int g, ae, pe, ee, dc, la;
    apply_reset();
    do_start();
    run_frame(1'b0, g, ae, pe, ee, dc, la);
    tests++;
    if (g != 256 || ae != 0 || pe != 0) begin
      fails++;
      $display("FAIL full_groups: got n=%0d aerr=%0d perr=%0d want 256 0 0",
               g, ae, pe);
    end
    tests++;
    if (dc != 1024 || la != 255) begin
      fails++;
      $display("FAIL full_done: got cyc=%0d addr=%0d want 1024 255",
               dc, la);
    end
    tests++;
    if (ee != 0) begin
      fails++;
      $display("FAIL full_enable: got %0d errors want 0", ee);
    end
    tests++;
    if (frame_busy !== 1'b1 || grp_valid !== 1'b1) begin
      fails++;
      $display("FAIL done_align: got busy=%b gv=%b want 1 1",
               frame_busy, grp_valid);
    end
    @(negedge clk);
    #4;
    tests++;
    if (frame_busy !== 1'b0 || frame_done !== 1'b0 ||
        sample_cnt !== 10'd0 || s2p_counter !== 2'd0) begin
      fails++;
      $display("FAIL after_done: got busy=%b fd=%b scnt=%0d ph=%0d want 0 0 0 0",
               frame_busy, frame_done, sample_cnt, s2p_counter);
    end
  endtask

  task automatic test_backpressure();
    int bad_rdy = 0;
    int bad_hold = 0;
    int exp_drop;
`ifdef S2P_DROP_CNT_EN
    exp_drop = 10;
`else
    exp_drop = 0;
`endif
    apply_reset();
    do_start();
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      core_ready = 1'b0;
      #4;
      if (c < 3 && in_ready !== 1'b1) bad_rdy++;
      if (c >= 3 &&
          (in_ready !== 1'b0 || s2p_enable !== 1'b0 ||
           s2p_counter !== 2'd3 ||
           sample_cnt !== 10'd3)) bad_hold++;
    end
    tests++;
    if (bad_rdy != 0) begin
      fails++;
      $display("FAIL ph012_no_stall: got %0d stalls want 0", bad_rdy);
    end
    tests++;
    if (bad_hold != 0) begin
      fails++;
      $display("FAIL stall_hold: got %0d bad cycles want 0", bad_hold);
    end
    @(negedge clk);
    core_ready = 1'b1;
    #4;
    tests++;
    if (in_ready !== 1'b1 || s2p_enable !== 1'b1) begin
      fails++;
      $display("FAIL release: got rdy=%b en=%b want 1 1",
               in_ready, s2p_enable);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #4;
    tests++;
    if (grp_valid !== 1'b1 || grp_addr !== 8'd0 ||
        s2p_counter !== 2'd0 || sample_cnt !== 10'd4) begin
      fails++;
      $display("FAIL grp_after_stall: got gv=%b a=%0d ph=%0d s=%0d want 1 0 0 4",
               grp_valid, grp_addr, s2p_counter, sample_cnt);
    end
    tests++;
    if (drop_cnt !== 16'(exp_drop)) begin
      fails++;
      $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, exp_drop);
    end
  endtask

  task automatic test_toggle_valid();
    int g, ae, pe, ee, dc, la;
    apply_reset();
    do_start();
    run_frame(1'b1, g, ae, pe, ee, dc, la);
    tests++;
    if (g != 256 || ae != 0 || pe != 0 || ee != 0) begin
      fails++;
      $display("FAIL toggle_groups: got n=%0d aerr=%0d perr=%0d eerr=%0d want 256 0 0 0",
               g, ae, pe, ee);
    end
    tests++;
    if (dc != 2047 || la != 255) begin
      fails++;
      $display("FAIL toggle_done: got cyc=%0d addr=%0d want 2047 255",
               dc, la);
    end
  endtask

  task automatic test_mid_reset();
    int g, ae, pe, ee, dc, la;
    int spurious = 0;
    apply_reset();
    do_start();
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
    end
    #4;
    tests++;
    if (sample_cnt !== 10'd499) begin
      fails++;
      $display("FAIL pre_reset_cnt: got %0d want 499", sample_cnt);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({in_ready, s2p_enable, s2p_counter,
         grp_valid, grp_addr, frame_busy,
         frame_done, sample_cnt, drop_cnt} !== '0) begin
      fails++;
      $display("FAIL mid_reset_outs: got rdy=%b busy=%b scnt=%0d want 0 0 0",
               in_ready, frame_busy, sample_cnt);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (frame_done !== 1'b0) spurious++;
    end
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #4;
    tests++;
    if (spurious != 0 || frame_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_discard: got fd=%0d busy=%b want 0 0",
               spurious, frame_busy);
    end
    do_start();
    run_frame(1'b0, g, ae, pe, ee, dc, la);
    tests++;
    if (g != 256 || ae != 0 || dc != 1024 || la != 255) begin
      fails++;
      $display("FAIL reframe: got n=%0d aerr=%0d cyc=%0d last=%0d want 256 0 1024 255",
               g, ae, dc, la);
    end
  endtask

  task automatic test_start_ignored();
    int dc = -1;
    int cnt100 = -1;
    apply_reset();
    do_start();
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      core_ready = 1'b1;
      start = (c == 50);
      #4;
      if (c == 100) cnt100 = int'(sample_cnt);
      if (frame_done === 1'b1) begin
        dc = c;
        break;
      end
    end
    in_valid = 1'b0;
    start = 1'b1;
    tests++;
    if (cnt100 != 100) begin
      fails++;
      $display("FAIL start_in_run: got scnt=%0d want 100", cnt100);
    end
    tests++;
    if (dc != 1024) begin
      fails++;
      $display("FAIL start_run_done: got cyc=%0d want 1024", dc);
    end
    @(negedge clk);
    start = 1'b0;
    #4;
    tests++;
    if (frame_busy !== 1'b0 || sample_cnt !== 10'd0) begin
      fails++;
      $display("FAIL start_in_done: got busy=%b scnt=%0d want 0 0",
               frame_busy, sample_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_toggle_valid();
    test_mid_reset();
    test_start_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
